// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an N-digit common-anode
// seven-segment display with a double-buffered, tear-free load path.
//
// Optional feature: define LEAD_ZERO_BLANK_EN to suppress leading zeros
// (digits from the top down whose nibble is 0 and dot is 0; digit 0 is never
// suppressed). Scan timing is identical with or without it.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   digits      hex nibble per digit, digit i = digits[4i+3:4i]
//   dots        per-digit decimal point request, 1 = lit
//   blank       per-digit blank request, 1 = digit (and dot) dark
//   load        single-cycle strobe capturing digits/dots/blank
//   seg         segment drive, active-low; [6:0] = abcdefg (a = bit 6), [7] = dp
//   an          anode enables, active-low, at most one low at a time
//   frame_tick  one-cycle pulse following each frame wrap / buffer swap
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dots,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    // Scan position
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    // Pending (written by load) and active (displayed) buffers
    logic [NUM_DIGITS-1:0][3:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]      pend_dot_q, pend_dot_d;
    logic [NUM_DIGITS-1:0]      pend_blk_q, pend_blk_d;
    logic                       pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0][3:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]      act_dot_q, act_dot_d;
    logic [NUM_DIGITS-1:0]      act_blk_q, act_blk_d;

    // Registered outputs
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  wrap;
    logic                  dark;
    logic [NUM_DIGITS-1:0] lz_sup;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            4'hF: s = 7'h38;
        endcase
        return s;
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    // Walk down from the most significant digit; suppression stops at the
    // first nonzero nibble or lit dot. Digit 0 always stays visible.
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_sup = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run       = run & (act_dig_q[i] == 4'h0) & ~act_dot_q[i];
            lz_sup[i] = run;
        end
    end
`else
    assign lz_sup = '0;
`endif

    assign slot_end = (cnt_q == CNT_MAX);
    assign wrap     = slot_end && (idx_q == IDX_MAX);

    // Scan counters and buffer handshake
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        pend_dig_d   = pend_dig_q;
        pend_dot_d   = pend_dot_q;
        pend_blk_d   = pend_blk_q;
        pend_valid_d = pend_valid_q;
        act_dig_d    = act_dig_q;
        act_dot_d    = act_dot_q;
        act_blk_d    = act_blk_q;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            pend_dig_d   = digits;
            pend_dot_d   = dots;
            pend_blk_d   = blank;
            pend_valid_d = 1'b1;
        end

        // Active only changes on a frame wrap; a load on the wrap edge
        // bypasses pending so it is shown without an extra frame of delay.
        if (wrap) begin
            if (load) begin
                act_dig_d    = digits;
                act_dot_d    = dots;
                act_blk_d    = blank;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_dig_d    = pend_dig_q;
                act_dot_d    = pend_dot_q;
                act_blk_d    = pend_blk_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    // Output decode from the current state; registered below (1-cycle lag)
    always_comb begin
        seg_d  = 8'hFF;
        an_d   = '1;
        tick_d = wrap;
        dark   = (32'(cnt_q) < BLANK_CYCLES) || act_blk_q[idx_q] || lz_sup[idx_q];
        if (!dark) begin
            an_d[idx_q] = 1'b0;
            seg_d       = {~act_dot_q[idx_q], hex7(act_dig_q[idx_q])};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_dig_q   <= '0;
            pend_dot_q   <= '0;
            pend_blk_q   <= '1;
            pend_valid_q <= 1'b0;
            act_dig_q    <= '0;
            act_dot_q    <= '0;
            act_blk_q    <= '1;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dot_q   <= pend_dot_d;
            pend_blk_q   <= pend_blk_d;
            pend_valid_q <= pend_valid_d;
            act_dig_q    <= act_dig_d;
            act_dot_q    <= act_dot_d;
            act_blk_q    <= act_blk_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            tick_q       <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   digits = '0;
    logic [3:0]    dots = '0;
    logic [3:0]    blank = '0;
    logic          load = 1'b0;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic          frame_tick;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: position within the frame since reset plus the two buffers
    int          m_pos;
    logic [15:0] m_act_dig, m_pend_dig;
    logic [3:0]  m_act_dot, m_pend_dot, m_act_bl, m_pend_bl;
    logic        m_pv;

    logic [6:0] hex7_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dots       (dots),
        .blank      (blank),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_act_dig  = '0;
        m_pend_dig = '0;
        m_act_dot  = '0;
        m_pend_dot = '0;
        m_act_bl   = '1;
        m_pend_bl  = '1;
        m_pv       = 1'b0;
    endtask

    // What the display should show for a given frame position: {an, seg}
    function automatic logic [11:0] model_out(input int pos);
        int         slot;
        int         c;
        logic       sup;
        logic [3:0] nib;
        logic [3:0] a;
        slot = (pos / SD) % ND;
        c    = pos % SD;
        sup  = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        if (slot > 0) begin
            sup = 1'b1;
            for (int j = slot; j < ND; j++)
                if (m_act_dig[4*j +: 4] != 4'h0 || m_act_dot[j]) sup = 1'b0;
        end
`endif
        if (c < BC || m_act_bl[slot] || sup) return {4'hF, 8'hFF};
        a       = 4'hF;
        a[slot] = 1'b0;
        nib     = m_act_dig[4*slot +: 4];
        return {a, ~m_act_dot[slot], hex7_tab[nib]};
    endfunction

    // One clock: drive inputs, update model at the edge, check #1 later
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dt,
                        input logic [3:0] bl);
        logic [11:0] exp_o;
        logic        exp_t;
        logic        wrap;
        load   = ld;
        digits = d;
        dots   = dt;
        blank  = bl;
        @(posedge clk);
        exp_o = model_out(m_pos);
        wrap  = (m_pos % FRAME) == FRAME - 1;
        exp_t = wrap;
        if (ld) begin
            m_pend_dig = d;
            m_pend_dot = dt;
            m_pend_bl  = bl;
            m_pv       = 1'b1;
        end
        if (wrap) begin
            if (ld) begin
                m_act_dig = d;
                m_act_dot = dt;
                m_act_bl  = bl;
                m_pv      = 1'b0;
            end else if (m_pv) begin
                m_act_dig = m_pend_dig;
                m_act_dot = m_pend_dot;
                m_act_bl  = m_pend_bl;
                m_pv      = 1'b0;
            end
        end
        m_pos++;
        #1;
        chk("an", 32'(an), 32'(exp_o[11:8]));
        chk("seg", 32'(seg), 32'(exp_o[7:0]));
        chk("frame_tick", 32'(frame_tick), 32'(exp_t));
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, digits, dots, blank);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rdt;
        logic [3:0]  rbl;
        model_reset();

        // Reset state
        #12;
        chk("reset_seg", 32'(seg), 32'hFF);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        #3 reset = 1'b0;

        // 1. No load: dark for 64+ cycles, tick every frame after the first
        idle(70);

        // 2. Scan timing with 1234, dot on digit 2
        step(1'b1, 16'h1234, 4'b0100, 4'b0000);
        idle(40);

        // 3. Tear-free: two loads in one frame, last one wins
        while ((m_pos % FRAME) != 5) idle(1);
        step(1'b1, 16'hAAAA, 4'h0, 4'h0);
        idle(3);
        step(1'b1, 16'h5555, 4'h0, 4'h0);
        idle(36);

        // 4. Load coincident with the wrap edge goes straight to active
        while ((m_pos % FRAME) != FRAME - 1) idle(1);
        step(1'b1, 16'hFFFF, 4'h0, 4'h0);
        idle(20);

        // 5. Blank digit 1, then asynchronous reset during slot 2
        step(1'b1, 16'h1234, 4'h0, 4'b0010);
        idle(36);
        while (((m_pos % FRAME) / SD) != 2 || (m_pos % SD) != 2) idle(1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_seg", 32'(seg), 32'hFF);
        chk("async_reset_an", 32'(an), 32'hF);
        chk("async_reset_tick", 32'(frame_tick), 32'h0);
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        idle(20);

        // 6. Leading-zero cases (expected values follow the build)
        step(1'b1, 16'h0070, 4'h0, 4'h0);
        idle(36);
        step(1'b1, 16'h0000, 4'h0, 4'h0);
        idle(36);
        step(1'b1, 16'h0000, 4'b0100, 4'h0);
        idle(36);

        // Randomized loads, zero-biased nibbles to exercise suppression
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < ND; j++)
                rd[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            rdt = 4'($urandom) & 4'($urandom);
            rbl = 4'($urandom) & 4'($urandom) & 4'($urandom);
            step($urandom_range(0, 6) == 0, rd, rdt, rbl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
